// File: rtl/dmem_seq_pkg.sv
// Shared types and default sizes for the data-memory port sequencer.
// The lane-index type is also meant for the writeback arbiter.
package dmem_seq_pkg;

  localparam int DEF_LANES = 4;
  localparam int DEF_AW    = 32;
  localparam int DEF_DW    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef logic [$clog2(DEF_LANES)-1:0] lane_idx_t;

endpackage

// File: rtl/dmem_port_sequencer_if.sv
// Single-ported data-memory bus between the sequencer (master) and the memory (slave).
interface dmem_port_sequencer_if
  import dmem_seq_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);

  // mem_en is a one-cycle strobe with no ready: a write is complete at the end of
  // its strobe cycle, and read data is valid on mem_rdata exactly MEM_LAT cycles later.
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_en,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_en,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/dmem_lane_pick.sv
// Lowest-set-bit priority encoder: returns the oldest requesting lane.
module dmem_lane_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int LW = $clog2(N);

  always_comb begin
    idx_o = '0;
    any_o = |req_i;
    // Scanning downwards lets the lowest set bit overwrite higher ones.
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[k]) idx_o = LW'(k);
    end
  end

endmodule

// File: rtl/dmem_port_sequencer.sv
// Serializes the M-stage lanes' loads/stores onto one data-memory port, stalling the group.
// Optional build macro DMEM_FASTPATH_EN: a lone store issues from IDLE without stalling.
module dmem_port_sequencer
  import dmem_seq_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int MEM_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  grp_valid,
  input  logic [LANES-1:0]      req_valid,
  input  logic [LANES-1:0]      req_write,
  input  logic [LANES*AW-1:0]   req_addr,
  input  logic [LANES*DW-1:0]   req_wdata,
  output logic                  stall_o,
  output logic [LANES*DW-1:0]   rdata_o,
  output state_e                state_o,
  dmem_port_sequencer_if.master mem
);

  localparam int LW = $clog2(LANES);
  localparam int CW = $clog2(MEM_LAT + 1);

  state_e               state_q, state_d;
  logic [LANES-1:0]     pend_q, pend_d;
  logic [LW-1:0]        lane_q, lane_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [LANES*DW-1:0]  rdata_q, rdata_d;

  logic [LANES-1:0]     pick_in;
  logic [LANES-1:0]     lane_mask;
  logic [LW-1:0]        pick_idx;
  logic                 pick_any;

  logic                 stall_c;
  logic                 en_c;
  logic                 we_c;
  logic [AW-1:0]        addr_c;
  logic [DW-1:0]        wdata_c;

  // In IDLE the encoder looks at the live request (fast path); afterwards at the captured set.
  assign pick_in = (state_q == IDLE) ? req_valid : pend_q;

  dmem_lane_pick #(.N(LANES)) u_pick (
    .req_i (pick_in),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    lane_mask           = '0;
    lane_mask[pick_idx] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    stall_c = 1'b0;
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;

    case (state_q)
      IDLE: begin
        if (grp_valid && (|req_valid)) begin
`ifdef DMEM_FASTPATH_EN
          if ($onehot(req_valid) && req_write[pick_idx]) begin
            en_c    = 1'b1;
            we_c    = 1'b1;
            addr_c  = req_addr[pick_idx*AW +: AW];
            wdata_c = req_wdata[pick_idx*DW +: DW];
          end else begin
            stall_c = 1'b1;
            pend_d  = req_valid;
            state_d = ISSUE;
          end
`else
          stall_c = 1'b1;
          pend_d  = req_valid;
          state_d = ISSUE;
`endif
        end
      end

      ISSUE: begin
        stall_c = 1'b1;
        if (pick_any) begin
          en_c    = 1'b1;
          we_c    = req_write[pick_idx];
          addr_c  = req_addr[pick_idx*AW +: AW];
          wdata_c = req_wdata[pick_idx*DW +: DW];
          lane_d  = pick_idx;
          pend_d  = pend_q & ~lane_mask;
          if (req_write[pick_idx]) begin
            state_d = (pend_d == '0) ? RELEASE : ISSUE;
          end else begin
            cnt_d   = CW'(MEM_LAT);
            state_d = WAIT;
          end
        end else begin
          state_d = RELEASE;
        end
      end

      WAIT: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - CW'(1);
        // The counter reads 1 in exactly the cycle the memory presents the word.
        if (cnt_q == CW'(1)) begin
          rdata_d[lane_q*DW +: DW] = mem.mem_rdata;
          state_d = (|pend_q) ? ISSUE : RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A reset cycle must never strobe memory or hold the pipeline.
    if (!reset) begin
      stall_c = 1'b0;
      en_c    = 1'b0;
      we_c    = 1'b0;
      addr_c  = '0;
      wdata_c = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      lane_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      lane_q  <= lane_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign stall_o       = stall_c;
  assign rdata_o       = rdata_q;
  assign state_o       = state_q;
  assign mem.mem_en    = en_c;
  assign mem.mem_we    = we_c;
  assign mem.mem_addr  = addr_c;
  assign mem.mem_wdata = wdata_c;

endmodule
